voice_alloc: RTL

VOICE_ALLOC -- requirements
Module: voice_alloc

---
 rtl/voice_alloc_pkg.sv | 14 +
 rtl/voice_alloc_if.sv | 16 +
 rtl/voice_age_tracker.sv | 41 ++++
 rtl/voice_alloc.sv | 126 ++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared definitions for the voice allocator and its neighbours (midi_rx, synth):
// FSM state enumeration and default note/velocity widths.
package voice_alloc_pkg;

    localparam int unsigned NOTE_WIDTH_DEF = 7;
    localparam int unsigned VEL_WIDTH_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_COMMIT = 2'd2
    } va_state_e;

endpackage

// File: rtl/voice_alloc_if.sv
// Note event handshake between an event source (master) and the voice allocator (slave).
interface voice_alloc_if #(
    parameter int unsigned NOTE_WIDTH = voice_alloc_pkg::NOTE_WIDTH_DEF,
    parameter int unsigned VEL_WIDTH  = voice_alloc_pkg::VEL_WIDTH_DEF
) ();

    logic                  ev_valid;
    logic                  ev_ready;
    logic                  ev_on;
    logic [NOTE_WIDTH-1:0] ev_note;
    logic [VEL_WIDTH-1:0]  ev_vel;

    modport master (output ev_valid, ev_on, ev_note, ev_vel, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_note, ev_vel, output ev_ready);

endinterface

// File: rtl/voice_age_tracker.sv
// Per-slot age ranks (0 = most recently played); finds the oldest slot and
// promotes a slot to rank 0 while ageing every slot that was younger than it.
module voice_age_tracker #(
    parameter int unsigned NUM_VOICES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          promote,
    input  logic [$clog2(NUM_VOICES)-1:0] promote_slot,
    output logic [$clog2(NUM_VOICES)-1:0] oldest
);

    localparam int unsigned IW = $clog2(NUM_VOICES);

    logic [NUM_VOICES-1:0][IW-1:0] rank;
    logic [IW-1:0]                 promote_rank;

    assign promote_rank = rank[promote_slot];

    always_comb begin
        oldest = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (rank[IW'(i)] == IW'(NUM_VOICES - 1)) oldest = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) rank[IW'(i)] <= IW'(i);
        end else if (promote) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (IW'(i) == promote_slot) begin
                    rank[IW'(i)] <= '0;
                end else if (rank[IW'(i)] < promote_rank) begin
                    rank[IW'(i)] <= rank[IW'(i)] + IW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off events onto voice slots with
// retrigger, lowest-free allocation and oldest-voice stealing; panic kills all gates.
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned NOTE_WIDTH = NOTE_WIDTH_DEF,
    parameter int unsigned VEL_WIDTH  = VEL_WIDTH_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    voice_alloc_if.slave                          ev,
    input  logic                                  panic,
    output logic [NUM_VOICES-1:0]                 voice_on,
    output logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] voice_note,
    output logic [NUM_VOICES-1:0][VEL_WIDTH-1:0]  voice_vel,
    output logic                                  steal
);

    localparam int unsigned IW = $clog2(NUM_VOICES);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] LOOKUP = ST_LOOKUP;
    localparam logic [1:0] COMMIT = ST_COMMIT;

    logic [1:0]            state;
    logic                  running;
    logic                  lat_on;
    logic [NOTE_WIDTH-1:0] lat_note;
    logic [VEL_WIDTH-1:0]  lat_vel;

    logic                  lk_hit, lk_free;
    logic [IW-1:0]         lk_hit_idx, lk_free_idx, oldest;
    logic                  hit_ok, free_ok;
    logic [IW-1:0]         hit_idx, free_idx, old_idx, tgt;
    logic                  do_alloc;

    // running holds ev_ready low through reset and releases it on the first edge after
    assign ev.ev_ready = running && (state == IDLE) && !panic;

    always_comb begin
        lk_hit      = 1'b0;
        lk_hit_idx  = '0;
        lk_free     = 1'b0;
        lk_free_idx = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!lk_hit && voice_on[IW'(i)] && voice_note[IW'(i)] == lat_note) begin
                lk_hit     = 1'b1;
                lk_hit_idx = IW'(i);
            end
            if (!lk_free && !voice_on[IW'(i)]) begin
                lk_free     = 1'b1;
                lk_free_idx = IW'(i);
            end
        end
    end

    assign tgt      = hit_ok ? hit_idx : (free_ok ? free_idx : old_idx);
    assign do_alloc = (state == COMMIT) && !panic && lat_on;

    voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_age (
        .clk          (clk),
        .rst          (rst),
        .promote      (do_alloc),
        .promote_slot (tgt),
        .oldest       (oldest)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            running    <= 1'b0;
            lat_on     <= 1'b0;
            lat_note   <= '0;
            lat_vel    <= '0;
            hit_ok     <= 1'b0;
            free_ok    <= 1'b0;
            hit_idx    <= '0;
            free_idx   <= '0;
            old_idx    <= '0;
            voice_on   <= '0;
            voice_note <= '0;
            voice_vel  <= '0;
            steal      <= 1'b0;
        end else begin
            running <= 1'b1;
            steal   <= 1'b0;
            if (panic) begin
                voice_on <= '0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ev.ev_valid && ev.ev_ready) begin
                            lat_on   <= ev.ev_on && (ev.ev_vel != '0);
                            lat_note <= ev.ev_note;
                            lat_vel  <= ev.ev_vel;
                            state    <= LOOKUP;
                        end
                    end
                    LOOKUP: begin
                        hit_ok   <= lk_hit;
                        hit_idx  <= lk_hit_idx;
                        free_ok  <= lk_free;
                        free_idx <= lk_free_idx;
                        old_idx  <= oldest;
                        state    <= COMMIT;
                    end
                    COMMIT: begin
                        if (lat_on) begin
                            voice_on[tgt]   <= 1'b1;
                            voice_note[tgt] <= lat_note;
                            voice_vel[tgt]  <= lat_vel;
                            steal           <= !hit_ok && !free_ok;
                        end else if (hit_ok) begin
                            voice_on[hit_idx] <= 1'b0;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
